uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver with an oversampled bit-centre sampler, configurable frame format
//  (data bits, parity, stop bits) and a first-word-fall-through RX FIFO with valid/ready pop.
//  Replaces the fixed 8N1 receive path on the picorv_uart side. Sticky error flags let firmware
//  and the uart_sender-driven benches detect corrupt frames.
// PARAMETERS
//  ClkFreq    12000000  core clock frequency, Hz
//  BaudRate   115200    line rate, baud
//  Oversample 8         samples per bit (>=4, even); tick divider Div = round(ClkFreq/(BaudRate*Oversample))
//  DataBits   8         payload bits per frame, 5..9
//  Parity     0         0 none, 1 odd, 2 even
//  StopBits   1         1 or 2
//  FifoDepth  16        RX FIFO entries, power of two >= 2
// PORTS
//  clk_i        in   1                     core clock
//  reset_ni     in   1                     asynchronous reset, active-low
//  rx_i         in   1                     serial line input, idle high, asynchronous to clk_i
//  data_o       out  DataBits              FIFO head word, valid only while valid_o=1
//  valid_o      out  1                     FIFO non-empty
//  ready_i      in   1                     consumer pops head when valid_o && ready_i
//  count_o      out  $clog2(FifoDepth)+1   current FIFO occupancy
//  overrun_o    out  1                     sticky: frame dropped because the FIFO was full
//  frame_err_o  out  1                     sticky: a stop bit was sampled low
//  parity_err_o out  1                     sticky: parity mismatch
//  clear_err_i  in   1                     synchronous clear of all three sticky flags
// BEHAVIOUR
//  - Reset (async assert, sync release inside block): all outputs 0, FSM IDLE, FIFO empty,
//    synchroniser flops preset to 1 so reset release never produces a false start.
//  - rx_i passes through a 2-flop synchroniser; every sampling decision uses the synchronised value.
//  - Tick counter wraps at Div-1 and runs only outside IDLE; it restarts at 0 on start detection.
//    Elaboration check: |actual baud - BaudRate| / BaudRate < 2%, else $fatal.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE: falling edge of synchronised rx -> START, tick count = 0.
//    START: after Oversample/2 ticks, sample. Low -> DATA. High -> IDLE (glitch rejected, no flag set).
//    DATA: sample every Oversample ticks, LSB first, DataBits samples. Next state is PARITY if Parity != 0, else STOP.
//    PARITY: one sample. Odd parity requires an odd number of ones over data+parity; even requires an even number.
//    STOP: StopBits samples spaced Oversample ticks apart. Any low sample sets frame_err and
//      discards the frame. After a low stop sample (break), the FSM waits for rx high before IDLE.
//  - A good frame is pushed on the cycle after the final stop-bit sample. It appears on data_o
//    with valid_o=1 one cycle later when the FIFO was empty (push-to-valid latency 1).
//    No dead time: IDLE is re-entered at the centre of the last stop bit.
//  - A frame with a parity error is dropped and sets parity_err. A frame with both errors sets both flags.
//  - FIFO: FWFT; data_o = mem[rd_ptr]. Pointers wrap modulo FifoDepth; count_o is exact.
//    Push when full with no pop: frame dropped, overrun set, FIFO contents unchanged.
//    Push and pop in the same cycle when full: both accepted, count unchanged.
//    Push and pop in the same cycle when empty: not possible, because valid_o=0.
//  - Sticky flags: set has priority over clear_err_i in the same cycle.
//  - Mid-operation reset: the frame in flight is lost, the FIFO is flushed and flags are cleared.
//    Reception resumes at the next falling edge after release.
// TESTING (ClkFreq=12e6, BaudRate=115200, Oversample=8 -> Div=13, 104 clk/bit unless noted)
//  1. 8N1: send 0xA5, then 0x3C, ready_i=0 -> count_o=2, data_o=0xA5. Pulse ready_i -> data_o=0x3C, count_o=1.
//  2. Parity=2, DataBits=7: send 0x55 with a wrong parity bit -> parity_err_o=1, count_o=0.
//     Then a correct 0x55 -> data_o=0x55. clear_err_i -> parity_err_o=0.
//  3. Stop bit forced low, then 3 bit-times low (break), then idle, then 0x11 -> frame_err_o=1, only 0x11 in FIFO.
//  4. FifoDepth=4, ready_i=0: send 5 frames 0x01..0x05 -> count_o=4, overrun_o=1,
//     pops return 0x01..0x04 in order.
//  5. 40-clk low glitch on rx_i while IDLE -> no push, no flags.
//     Then StopBits=2 frame 0x80 -> accepted.
//  6. Assert reset_ni=0 mid-data of a frame with 2 entries queued -> count_o=0, flags 0.
//     The next frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with an oversampled bit-centre sampler, configurable frame
//   format (DataBits payload bits, optional odd/even parity, 1 or 2 stop bits)
//   feeding a first-word-fall-through receive FIFO with a valid/ready pop side.
//   Sticky error flags report corrupt frames and FIFO overflow.
//
// Ports
//   clk_i        in   core clock
//   reset_ni     in   asynchronous active-low reset (released synchronously inside)
//   rx_i         in   serial line, idle high, asynchronous to clk_i
//   data_o       out  FIFO head word (DataBits), forced to 0 while the FIFO is empty
//   valid_o      out  FIFO non-empty
//   ready_i      in   pops the head word when valid_o && ready_i
//   count_o      out  FIFO occupancy, $clog2(FifoDepth)+1 bits
//   overrun_o    out  sticky: a good frame was dropped because the FIFO was full
//   frame_err_o  out  sticky: a stop bit was sampled low
//   parity_err_o out  sticky: parity mismatch
//   clear_err_i  in   synchronous clear of the three sticky flags (a set wins)

module uart_rx_fifo #(
    parameter int ClkFreq    = 12000000,
    parameter int BaudRate   = 115200,
    parameter int Oversample = 8,
    parameter int DataBits   = 8,
    parameter int Parity     = 0,
    parameter int StopBits   = 1,
    parameter int FifoDepth  = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           rx_i,
    output logic [DataBits-1:0]            data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [$clog2(FifoDepth):0]     count_o,
    output logic                           overrun_o,
    output logic                           frame_err_o,
    output logic                           parity_err_o,
    input  logic                           clear_err_i
);

    // Tick divider: rounded ClkFreq / (BaudRate * Oversample).
    localparam longint LineRate = longint'(BaudRate) * longint'(Oversample);
    localparam longint DivL     = (longint'(ClkFreq) + LineRate / 2) / LineRate;
    localparam longint Nominal  = DivL * LineRate;
    localparam longint ErrAbs   = (longint'(ClkFreq) > Nominal) ? (longint'(ClkFreq) - Nominal)
                                                                 : (Nominal - longint'(ClkFreq));
    localparam int     Div      = int'(DivL);
    localparam int     TW       = (Div > 1) ? $clog2(Div) : 1;
    localparam int     OW       = $clog2(Oversample);
    localparam int     AW       = $clog2(FifoDepth);
    localparam int     CW       = AW + 1;

    // Actual baud error below 2 %: |ClkFreq - Div*Ovs*Baud| * 50 < Div*Ovs*Baud.
    if (DivL < 1 || ErrAbs * 50 >= Nominal) begin : g_baud_check
        $fatal(1, "uart_rx_fifo: baud error of tick divider is 2%% or more");
    end
    if (Oversample < 4 || (Oversample % 2) != 0) begin : g_ovs_check
        $fatal(1, "uart_rx_fifo: Oversample must be even and >= 4");
    end
    if (DataBits < 5 || DataBits > 9 || Parity < 0 || Parity > 2 ||
        StopBits < 1 || StopBits > 2 || FifoDepth < 2 ||
        (FifoDepth & (FifoDepth - 1)) != 0) begin : g_fmt_check
        $fatal(1, "uart_rx_fifo: illegal frame format or FIFO depth");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    logic                rst_meta;
    logic                rst_n_sync;
    logic                rx_p0;
    logic                rx_p1;
    logic                rx_p2;
    logic                fall;

    state_t              state;
    state_t              state_next;
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [OW-1:0]       os_cnt;
    logic [OW-1:0]       os_target;
    logic                sample;
    logic [3:0]          bit_cnt;

    logic                shift_en;
    logic                par_chk;
    logic                par_mismatch;
    logic                par_bad;
    logic                stop_bad;
    logic                frame_ok;

    logic [DataBits-1:0] shreg;
    logic [DataBits-1:0] push_data;
    logic                push_req;

    logic [DataBits-1:0] mem [FifoDepth];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                full;
    logic                pop;
    logic                push_ok;

    // Reset: asserts immediately, releases two clocks after reset_ni rises.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    // Stage p0/p1: line synchroniser; p2 keeps the previous synchronised value
    // for edge detection. Preset high so reset release never looks like a start.
    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign fall = rx_p2 & ~rx_p1;

    // Oversample tick and sample strobe; START waits half a bit, others a full bit.
    assign tick      = (state != S_IDLE) && (tick_cnt == TW'(Div - 1));
    assign os_target = (state == S_START) ? OW'(Oversample / 2 - 1) : OW'(Oversample - 1);
    assign sample    = tick && (os_cnt == os_target);

    assign par_mismatch = ((^shreg) ^ rx_p1) != (Parity == 1);

    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        par_chk    = 1'b0;
        stop_bad   = 1'b0;
        frame_ok   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) state_next = S_START;
            end
            S_START: begin
                if (sample) state_next = rx_p1 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'(DataBits - 1))
                        state_next = (Parity != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_chk    = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (!rx_p1) begin
                        stop_bad   = 1'b1;
                        state_next = S_BREAK_WAIT;
                    end else if (bit_cnt == 4'(StopBits - 1)) begin
                        frame_ok   = !par_bad;
                        state_next = S_IDLE;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (rx_p1) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bit-timing counters; all restart at zero on start detection.
    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
        end else begin
            if (state == S_IDLE || tick_cnt == TW'(Div - 1))
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);

            if (state == S_IDLE || sample)
                os_cnt <= '0;
            else if (tick)
                os_cnt <= os_cnt + OW'(1);

            if (state_next != state)
                bit_cnt <= '0;
            else if (sample)
                bit_cnt <= bit_cnt + 4'd1;

            if (state == S_IDLE)
                par_bad <= 1'b0;
            else if (par_chk && par_mismatch)
                par_bad <= 1'b1;
        end
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk_i) begin
        if (shift_en) shreg <= {rx_p1, shreg[DataBits-1:1]};
        if (frame_ok) push_data <= shreg;
    end

    // Stage p1: push one cycle after the final stop sample.
    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) push_req <= 1'b0;
        else             push_req <= frame_ok;
    end

    assign full    = (count_o == CW'(FifoDepth));
    assign valid_o = (count_o != '0);
    assign pop     = valid_o && ready_i;
    assign push_ok = push_req && (!full || pop);
    assign data_o  = valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as clear_err_i wins.
    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            overrun_o    <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (push_req && full && !pop) overrun_o <= 1'b1;
            else if (clear_err_i)         overrun_o <= 1'b0;

            if (stop_bad)                 frame_err_o <= 1'b1;
            else if (clear_err_i)         frame_err_o <= 1'b0;

            if (par_chk && par_mismatch)  parity_err_o <= 1'b1;
            else if (clear_err_i)         parity_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int BIT = 104;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic rx_line [4];
    logic ready   [4];
    logic clr     [4];

    // a: 8N1 depth 16; b: 7E1; c: 8N1 depth 4; d: 8N2
    logic [7:0] a_data;  logic a_valid; logic [4:0] a_count; logic a_ovr, a_ferr, a_perr;
    logic [6:0] b_data;  logic b_valid; logic [4:0] b_count; logic b_ovr, b_ferr, b_perr;
    logic [7:0] c_data;  logic c_valid; logic [2:0] c_count; logic c_ovr, c_ferr, c_perr;
    logic [7:0] d_data;  logic d_valid; logic [4:0] d_count; logic d_ovr, d_ferr, d_perr;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo u_a (
        .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_line[0]), .data_o(a_data), .valid_o(a_valid),
        .ready_i(ready[0]), .count_o(a_count), .overrun_o(a_ovr), .frame_err_o(a_ferr),
        .parity_err_o(a_perr), .clear_err_i(clr[0]));

    uart_rx_fifo #(.DataBits(7), .Parity(2)) u_b (
        .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_line[1]), .data_o(b_data), .valid_o(b_valid),
        .ready_i(ready[1]), .count_o(b_count), .overrun_o(b_ovr), .frame_err_o(b_ferr),
        .parity_err_o(b_perr), .clear_err_i(clr[1]));

    uart_rx_fifo #(.FifoDepth(4)) u_c (
        .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_line[2]), .data_o(c_data), .valid_o(c_valid),
        .ready_i(ready[2]), .count_o(c_count), .overrun_o(c_ovr), .frame_err_o(c_ferr),
        .parity_err_o(c_perr), .clear_err_i(clr[2]));

    uart_rx_fifo #(.StopBits(2)) u_d (
        .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_line[3]), .data_o(d_data), .valid_o(d_valid),
        .ready_i(ready[3]), .count_o(d_count), .overrun_o(d_ovr), .frame_err_o(d_ferr),
        .parity_err_o(d_perr), .clear_err_i(clr[3]));

    task automatic drive_bit(input int idx, input logic v);
        rx_line[idx] = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    // pm: 0 none, 1 odd, 2 even; flip inverts the parity bit; stop_low forces stop bits low
    task automatic send_frame(input int idx, input logic [8:0] d, input int nb, input int pm,
                              input bit flip, input int sb, input bit stop_low);
        logic p;
        p = 1'b0;
        drive_bit(idx, 1'b0);
        for (int i = 0; i < nb; i++) begin
            drive_bit(idx, d[i]);
            p = p ^ d[i];
        end
        if (pm != 0) drive_bit(idx, ((pm == 2) ? p : ~p) ^ flip);
        for (int i = 0; i < sb; i++) drive_bit(idx, stop_low ? 1'b0 : 1'b1);
    endtask

    task automatic pop_one(input int idx);
        ready[idx] = 1'b1;
        @(posedge clk);
        #1;
        ready[idx] = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear(input int idx);
        clr[idx] = 1'b1;
        @(posedge clk);
        #1;
        clr[idx] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", a_valid); end
        total++; if (a_count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", a_count); end
        total++; if (a_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", a_data); end
        total++; if ({a_ovr, a_ferr, a_perr} !== 3'b000)
            begin bad++; $display("FAIL rst_flags got=%b want=000", {a_ovr, a_ferr, a_perr}); end
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (a_count !== 5'd0 || a_valid !== 1'b0)
            begin bad++; $display("FAIL rst_release got=%0d/%b want=0/0", a_count, a_valid); end
    endtask

    task automatic test_8n1;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b0);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (a_count !== 5'd2) begin bad++; $display("FAIL t1_count got=%0d want=2", a_count); end
        total++; if (a_data !== 8'hA5) begin bad++; $display("FAIL t1_head got=%h want=a5", a_data); end
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b want=1", a_valid); end
        pop_one(0);
        total++; if (a_data !== 8'h3C) begin bad++; $display("FAIL t1_head2 got=%h want=3c", a_data); end
        total++; if (a_count !== 5'd1) begin bad++; $display("FAIL t1_count2 got=%0d want=1", a_count); end
        pop_one(0);
        total++; if (a_valid !== 1'b0 || a_count !== 5'd0)
            begin bad++; $display("FAIL t1_empty got=%b/%0d want=0/0", a_valid, a_count); end
        total++; if ({a_ovr, a_ferr, a_perr} !== 3'b000)
            begin bad++; $display("FAIL t1_flags got=%b want=000", {a_ovr, a_ferr, a_perr}); end
    endtask

    task automatic test_parity;
        send_frame(1, 9'h055, 7, 2, 1'b1, 1, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (b_perr !== 1'b1) begin bad++; $display("FAIL t2_perr got=%b want=1", b_perr); end
        total++; if (b_count !== 5'd0) begin bad++; $display("FAIL t2_drop got=%0d want=0", b_count); end
        total++; if (b_ferr !== 1'b0) begin bad++; $display("FAIL t2_ferr got=%b want=0", b_ferr); end
        send_frame(1, 9'h055, 7, 2, 1'b0, 1, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (b_count !== 5'd1 || b_data !== 7'h55)
            begin bad++; $display("FAIL t2_good got=%0d/%h want=1/55", b_count, b_data); end
        pulse_clear(1);
        total++; if (b_perr !== 1'b0) begin bad++; $display("FAIL t2_clear got=%b want=0", b_perr); end
        total++; if (b_count !== 5'd1) begin bad++; $display("FAIL t2_keep got=%0d want=1", b_count); end
    endtask

    task automatic test_break;
        send_frame(0, 9'h042, 8, 0, 1'b0, 1, 1'b1);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
        for (int i = 0; i < 2; i++) drive_bit(0, 1'b1);
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (a_ferr !== 1'b1) begin bad++; $display("FAIL t3_ferr got=%b want=1", a_ferr); end
        total++; if (a_perr !== 1'b0) begin bad++; $display("FAIL t3_perr got=%b want=0", a_perr); end
        total++; if (a_count !== 5'd1) begin bad++; $display("FAIL t3_count got=%0d want=1", a_count); end
        total++; if (a_data !== 8'h11) begin bad++; $display("FAIL t3_data got=%h want=11", a_data); end
        pop_one(0);
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) send_frame(2, 9'(i), 8, 0, 1'b0, 1, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (c_count !== 3'd4) begin bad++; $display("FAIL t4_count got=%0d want=4", c_count); end
        total++; if (c_ovr !== 1'b1) begin bad++; $display("FAIL t4_ovr got=%b want=1", c_ovr); end
        for (int i = 1; i <= 4; i++) begin
            total++; if (c_data !== 8'(i))
                begin bad++; $display("FAIL t4_pop got=%h want=%h", c_data, 8'(i)); end
            pop_one(2);
        end
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL t4_empty got=%b want=0", c_valid); end
    endtask

    task automatic test_glitch_stop2;
        rx_line[3] = 1'b0;
        repeat (40) @(posedge clk);
        #1 rx_line[3] = 1'b1;
        repeat (300) @(negedge clk);
        total++; if (d_count !== 5'd0) begin bad++; $display("FAIL t5_glitch got=%0d want=0", d_count); end
        total++; if ({d_ovr, d_ferr, d_perr} !== 3'b000)
            begin bad++; $display("FAIL t5_flags got=%b want=000", {d_ovr, d_ferr, d_perr}); end
        send_frame(3, 9'h080, 8, 0, 1'b0, 2, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (d_count !== 5'd1 || d_data !== 8'h80)
            begin bad++; $display("FAIL t5_stop2 got=%0d/%h want=1/80", d_count, d_data); end
        total++; if (d_ferr !== 1'b0) begin bad++; $display("FAIL t5_ferr got=%b want=0", d_ferr); end
    endtask

    task automatic test_reset_mid;
        send_frame(0, 9'h012, 8, 0, 1'b0, 1, 1'b0);
        send_frame(0, 9'h034, 8, 0, 1'b0, 1, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        @(negedge clk);
        total++; if (a_count !== 5'd2) begin bad++; $display("FAIL t6_pre got=%0d want=2", a_count); end
        reset_n = 1'b0;
        rx_line[0] = 1'b1;
        @(negedge clk);
        total++; if (a_count !== 5'd0 || a_valid !== 1'b0)
            begin bad++; $display("FAIL t6_flush got=%0d/%b want=0/0", a_count, a_valid); end
        total++; if ({a_ovr, a_ferr, a_perr} !== 3'b000)
            begin bad++; $display("FAIL t6_flags got=%b want=000", {a_ovr, a_ferr, a_perr}); end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        total++; if (a_count !== 5'd0) begin bad++; $display("FAIL t6_idle got=%0d want=0", a_count); end
        #1;
        send_frame(0, 9'h07E, 8, 0, 1'b0, 1, 1'b0);
        repeat (20) @(negedge clk);
        total++; if (a_count !== 5'd1 || a_data !== 8'h7E)
            begin bad++; $display("FAIL t6_next got=%0d/%h want=1/7e", a_count, a_data); end
        total++; if (a_ferr !== 1'b0) begin bad++; $display("FAIL t6_ferr got=%b want=0", a_ferr); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rx_line[i] = 1'b1;
            ready[i]   = 1'b0;
            clr[i]     = 1'b0;
        end
        test_reset;
        test_8n1;
        test_parity;
        test_break;
        test_overrun;
        test_glitch_stop2;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
